ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined CPU. Sits directly downstream of the ID/EX pipeline register and consumes its control, data and register-index outputs.
- Performs operand forwarding, ALU operation, branch-target and zero computation, and a multi-cycle MULT. Registers results into an internal EX/MEM pipeline register.
- Stalls the upstream pipeline while a multiply is in progress.

Parameters:
- size, 32, datapath width
- MUL_CYCLES, 32, shift-add iterations per MULT (must equal size)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- idex_aluop_i  in  3  ALU operation class
- idex_regwrite_i, idex_alusrc_i, idex_regdst_i, idex_branch_i, idex_memwrite_i, idex_memread_i, idex_memtoreg_i  in  1 each  control bits from ID/EX
- idex_add_i  in  size  PC+4
- idex_rsdata_i, idex_rtdata_i  in  size  register-file operands
- idex_se_i  in  size  sign-extended immediate; bits [5:0] are funct
- idex_rs_i, idex_rt_i, idex_rd_i  in  5  register indices
- memwb_regwrite_i  in  1  MEM/WB write enable
- memwb_rd_i  in  5  MEM/WB destination register
- memwb_data_i  in  size  MEM/WB writeback value
- stall_o  out  1  hold PC, IF/ID and ID/EX (combinational)
- exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o, exmem_memwrite_o, exmem_branch_o, exmem_zero_o  out  1 each  registered
- exmem_target_o  out  size  branch target
- exmem_alu_o  out  size  ALU/MULT result
- exmem_wdata_o  out  size  forwarded RT value for stores
- exmem_wreg_o  out  5  destination register

Behaviour:
- Reset: rst_n low asynchronously clears every exmem_* output to 0 and sets the FSM to IDLE. stall_o is 0 while in reset. Reset mid-multiply abandons the multiply with no partial result.
- Forwarding, A operand (from rs); B operand from rt uses the same rules:
  - EX/MEM hit: exmem_regwrite_o=1, exmem_memtoreg_o=0, exmem_wreg_o!=0 and equal to rs. Source is exmem_alu_o.
  - Otherwise MEM/WB hit: memwb_regwrite_i=1, memwb_rd_i!=0 and equal to rs. Source is memwb_data_i.
  - Otherwise idex_rsdata_i.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded. Load-use hazards are resolved upstream and are not handled here.
- ALU operand B: idex_se_i if idex_alusrc_i=1, else forwarded B.
- ALUop decode:
  - 000 add; 001 sub; 011 slt (signed); 100 or; 101 and; 110 lui (B<<16); 111 add.
  - 010 R-type by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt signed, 0x18 MULT. Any other funct gives result 0.
- Arithmetic: all results truncated mod 2^size with no overflow detection. zero = (result == 0). target = idex_add_i + (idex_se_i << 2). wreg = regdst ? rd : rt. wdata = forwarded B (pre-ALUSrc).
- Non-MULT instructions: single cycle. All exmem_* outputs load on every rising edge with the computed values.
- FSM states:
  - IDLE: MULT decoded, so stall_o=1, forwarded A/B are captured into multiplicand/multiplier registers, product cleared, counter cleared, next state BUSY. The EX/MEM control bits load 0 (bubble).
  - BUSY: stall_o=1. Each cycle, if multiplier[0] then product += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. Move to DONE after the iteration with counter==MUL_CYCLES-1. EX/MEM loads a bubble every cycle.
  - DONE: stall_o=0. EX/MEM loads the product (low size bits) as exmem_alu_o plus the held instruction's controls, wreg and zero. Next state IDLE.
- MULT timing: stall_o is high for MUL_CYCLES+1 cycles. The result appears on exmem_alu_o MUL_CYCLES+2 edges after the MULT enters EX.
- Operands are captured at IDLE, so forwarding-source changes during BUSY do not affect the product. Upstream holds ID/EX inputs stable while stall_o=1.
- A MULT immediately following a MULT: the second one is seen in IDLE the cycle after DONE and restarts the sequence. The DONE-to-IDLE transition never re-triggers on the same instruction, because the new instruction is only presented after stall_o falls.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY (counter=10) -> all exmem_* = 0, stall_o=0 at once. Release, then issue add -> normal result next edge.
- R-type add, rs=8 (5), rt=9 (7), ALUop=010, funct=0x20, regdst=1, rd=10 -> exmem_alu_o=12, exmem_wreg_o=10, exmem_zero_o=0 after one edge.
- Forwarding priority: previous instr writes r8=0x11 (EX/MEM) and MEM/WB also writes r8=0x22, next instr sub r10,r8,r0 -> exmem_alu_o=0x11. Repeat targeting r0 -> no forwarding, regfile value used.
- Branch: beq, ALUop=001, rs=rt=3, add=0x100, se=4 -> exmem_zero_o=1, exmem_target_o=0x110, exmem_branch_o=1.
- MULT 0xFFFF_FFFF × 3 -> stall_o high 33 cycles, 33 bubbles on exmem_regwrite_o=0, then exmem_alu_o=0xFFFF_FFFD with regwrite=1.
- slt signed: A=0xFFFF_FFFF, B=1 -> exmem_alu_o=1. Undefined funct 0x3F -> exmem_alu_o=0, exmem_zero_o=1.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of the execute stage
interface ex_stage_if #(parameter int size = 32);
    logic [2:0]      idex_aluop_i;
    logic            idex_regwrite_i, idex_alusrc_i, idex_regdst_i, idex_branch_i;
    logic            idex_memwrite_i, idex_memread_i, idex_memtoreg_i;
    logic [size-1:0] idex_add_i, idex_rsdata_i, idex_rtdata_i, idex_se_i;
    logic [4:0]      idex_rs_i, idex_rt_i, idex_rd_i;
    logic            memwb_regwrite_i;
    logic [4:0]      memwb_rd_i;
    logic [size-1:0] memwb_data_i;
    logic            stall_o;
    logic            exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o;
    logic            exmem_memwrite_o, exmem_branch_o, exmem_zero_o;
    logic [size-1:0] exmem_target_o, exmem_alu_o, exmem_wdata_o;
    logic [4:0]      exmem_wreg_o;

    modport master (
        output idex_aluop_i, idex_regwrite_i, idex_alusrc_i, idex_regdst_i, idex_branch_i,
               idex_memwrite_i, idex_memread_i, idex_memtoreg_i, idex_add_i, idex_rsdata_i,
               idex_rtdata_i, idex_se_i, idex_rs_i, idex_rt_i, idex_rd_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        input  stall_o, exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o, exmem_memwrite_o,
               exmem_branch_o, exmem_zero_o, exmem_target_o, exmem_alu_o, exmem_wdata_o,
               exmem_wreg_o
    );

    modport slave (
        input  idex_aluop_i, idex_regwrite_i, idex_alusrc_i, idex_regdst_i, idex_branch_i,
               idex_memwrite_i, idex_memread_i, idex_memtoreg_i, idex_add_i, idex_rsdata_i,
               idex_rtdata_i, idex_se_i, idex_rs_i, idex_rt_i, idex_rd_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        output stall_o, exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o, exmem_memwrite_o,
               exmem_branch_o, exmem_zero_o, exmem_target_o, exmem_alu_o, exmem_wdata_o,
               exmem_wreg_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, branch target, shift-add MULT and EX/MEM register
module ex_stage #(
    parameter int size       = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic       clk_i,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state, w_next;
    logic [size-1:0] r_mcand, r_mplier, r_prod;
    logic [CW-1:0]   r_cnt;
    logic            r_regwrite, r_memtoreg, r_memread, r_memwrite, r_branch, r_zero;
    logic [size-1:0] r_target, r_alu, r_wdata;
    logic [4:0]      r_wreg;
    logic [size-1:0] w_a, w_fb, w_b, w_res, w_alu;
    logic            w_is_mult, w_bubble, w_stall, w_lt;

    // EX/MEM takes priority over MEM/WB; register 0 never forwards
    assign w_a = (r_regwrite && !r_memtoreg && r_wreg != 5'd0 && r_wreg == bus.idex_rs_i) ? r_alu :
                 (bus.memwb_regwrite_i && bus.memwb_rd_i != 5'd0 && bus.memwb_rd_i == bus.idex_rs_i) ? bus.memwb_data_i :
                 bus.idex_rsdata_i;
    assign w_fb = (r_regwrite && !r_memtoreg && r_wreg != 5'd0 && r_wreg == bus.idex_rt_i) ? r_alu :
                  (bus.memwb_regwrite_i && bus.memwb_rd_i != 5'd0 && bus.memwb_rd_i == bus.idex_rt_i) ? bus.memwb_data_i :
                  bus.idex_rtdata_i;
    assign w_b       = bus.idex_alusrc_i ? bus.idex_se_i : w_fb;
    assign w_lt      = $signed(w_a) < $signed(w_b);
    assign w_is_mult = bus.idex_aluop_i == 3'b010 && bus.idex_se_i[5:0] == 6'h18;

    always_comb begin
        w_res = '0;
        case (bus.idex_aluop_i)
            3'b000, 3'b111: w_res = w_a + w_b;
            3'b001:         w_res = w_a - w_b;
            3'b011:         w_res = {{(size-1){1'b0}}, w_lt};
            3'b100:         w_res = w_a | w_b;
            3'b101:         w_res = w_a & w_b;
            3'b110:         w_res = w_b << 16;
            default:
                case (bus.idex_se_i[5:0])
                    6'h20:   w_res = w_a + w_b;
                    6'h22:   w_res = w_a - w_b;
                    6'h24:   w_res = w_a & w_b;
                    6'h25:   w_res = w_a | w_b;
                    6'h2A:   w_res = {{(size-1){1'b0}}, w_lt};
                    default: w_res = '0;
                endcase
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            IDLE: begin
                w_next   = w_is_mult ? BUSY : IDLE;
                w_stall  = w_is_mult;
                w_bubble = w_is_mult;
            end
            BUSY: begin
                w_next   = r_cnt == CW'(MUL_CYCLES - 1) ? DONE : BUSY;
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_alu       = r_state == DONE ? r_prod : w_res;
    assign bus.stall_o = rst_n && w_stall;

    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == IDLE && w_is_mult) begin
            r_mcand  <= w_a;
            r_mplier <= w_fb;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_prod   <= r_mplier[0] ? r_prod + r_mcand : r_prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end

    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            {r_regwrite, r_memtoreg, r_memread, r_memwrite, r_branch, r_zero} <= '0;
            {r_target, r_alu, r_wdata, r_wreg} <= '0;
        end else if (w_bubble) begin
            {r_regwrite, r_memtoreg, r_memread, r_memwrite, r_branch, r_zero} <= '0;
            {r_target, r_alu, r_wdata, r_wreg} <= '0;
        end else begin
            r_regwrite <= bus.idex_regwrite_i;
            r_memtoreg <= bus.idex_memtoreg_i;
            r_memread  <= bus.idex_memread_i;
            r_memwrite <= bus.idex_memwrite_i;
            r_branch   <= bus.idex_branch_i;
            r_zero     <= w_alu == '0;
            r_target   <= bus.idex_add_i + (bus.idex_se_i << 2);
            r_alu      <= w_alu;
            r_wdata    <= w_fb;
            r_wreg     <= bus.idex_regdst_i ? bus.idex_rd_i : bus.idex_rt_i;
        end

    assign bus.exmem_regwrite_o = r_regwrite;
    assign bus.exmem_memtoreg_o = r_memtoreg;
    assign bus.exmem_memread_o  = r_memread;
    assign bus.exmem_memwrite_o = r_memwrite;
    assign bus.exmem_branch_o   = r_branch;
    assign bus.exmem_zero_o     = r_zero;
    assign bus.exmem_target_o   = r_target;
    assign bus.exmem_alu_o      = r_alu;
    assign bus.exmem_wdata_o    = r_wdata;
    assign bus.exmem_wreg_o     = r_wreg;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed results for the execute stage
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    ex_stage_if #(.size(32)) bus ();
    ex_stage #(.size(32), .MUL_CYCLES(32)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.idex_aluop_i = 3'b000;
        {bus.idex_regwrite_i, bus.idex_alusrc_i, bus.idex_regdst_i, bus.idex_branch_i} = '0;
        {bus.idex_memwrite_i, bus.idex_memread_i, bus.idex_memtoreg_i} = '0;
        {bus.idex_add_i, bus.idex_rsdata_i, bus.idex_rtdata_i, bus.idex_se_i} = '0;
        {bus.idex_rs_i, bus.idex_rt_i, bus.idex_rd_i} = '0;
        bus.memwb_regwrite_i = 1'b0;
        bus.memwb_rd_i = 5'd0;
        bus.memwb_data_i = '0;
    endtask

    task automatic run_alu(input string tag, input logic [2:0] op, input logic [31:0] se,
                           input logic src, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        clr();
        bus.idex_aluop_i  = op;
        bus.idex_se_i     = se;
        bus.idex_alusrc_i = src;
        bus.idex_rs_i     = 5'd1;
        bus.idex_rt_i     = 5'd2;
        bus.idex_rsdata_i = a;
        bus.idex_rtdata_i = b;
        step();
        check(tag, bus.exmem_alu_o, exp);
        check({tag, ".zero"}, {31'd0, bus.exmem_zero_o}, {31'd0, exp == 32'd0});
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n_st, n_bub;
        clr();
        bus.idex_aluop_i    = 3'b010;
        bus.idex_se_i       = 32'h18;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_regdst_i   = 1'b1;
        bus.idex_rs_i       = 5'd1;
        bus.idex_rt_i       = 5'd2;
        bus.idex_rd_i       = 5'd12;
        bus.idex_rsdata_i   = a;
        bus.idex_rtdata_i   = b;
        n_st  = 0;
        n_bub = 0;
        #1;
        for (int i = 0; i < 40 && bus.stall_o; i++) begin
            n_st++;
            step();
            if (bus.exmem_regwrite_o == 1'b0) n_bub++;
        end
        check({tag, ".stalls"}, n_st, 33);
        check({tag, ".bubbles"}, n_bub, 33);
        step();
        check({tag, ".alu"}, bus.exmem_alu_o, exp);
        check({tag, ".regwrite"}, {31'd0, bus.exmem_regwrite_o}, 32'd1);
        check({tag, ".wreg"}, {27'd0, bus.exmem_wreg_o}, 32'd12);
    endtask

    initial begin
        clr();
        bus.idex_aluop_i    = 3'b010;
        bus.idex_se_i       = 32'h18;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_rsdata_i   = 32'h5;
        #2 rst_n = 1'b0;
        repeat (3) step();
        check("rst.alu", bus.exmem_alu_o, 32'd0);
        check("rst.regwrite", {31'd0, bus.exmem_regwrite_o}, 32'd0);
        check("rst.stall", {31'd0, bus.stall_o}, 32'd0);
        clr();
        @(negedge clk) rst_n = 1'b1;
        step();

        clr();
        bus.idex_aluop_i    = 3'b010;
        bus.idex_se_i       = 32'h20;
        bus.idex_regdst_i   = 1'b1;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_rs_i       = 5'd8;
        bus.idex_rsdata_i   = 32'd5;
        bus.idex_rt_i       = 5'd9;
        bus.idex_rtdata_i   = 32'd7;
        bus.idex_rd_i       = 5'd10;
        step();
        check("add.alu", bus.exmem_alu_o, 32'd12);
        check("add.wreg", {27'd0, bus.exmem_wreg_o}, 32'd10);
        check("add.zero", {31'd0, bus.exmem_zero_o}, 32'd0);
        check("add.target", bus.exmem_target_o, 32'h80);

        clr();
        bus.idex_alusrc_i   = 1'b1;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_se_i       = 32'h11;
        bus.idex_rt_i       = 5'd8;
        step();
        check("wr8.alu", bus.exmem_alu_o, 32'h11);
        clr();
        bus.idex_aluop_i     = 3'b010;
        bus.idex_se_i        = 32'h22;
        bus.idex_regdst_i    = 1'b1;
        bus.idex_regwrite_i  = 1'b1;
        bus.idex_rd_i        = 5'd10;
        bus.idex_rs_i        = 5'd8;
        bus.idex_rsdata_i    = 32'h99;
        bus.memwb_regwrite_i = 1'b1;
        bus.memwb_rd_i       = 5'd8;
        bus.memwb_data_i     = 32'h22;
        step();
        check("fwd.exmem", bus.exmem_alu_o, 32'h11);
        step();
        check("fwd.memwb", bus.exmem_alu_o, 32'h22);

        clr();
        bus.idex_alusrc_i   = 1'b1;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_se_i       = 32'h11;
        step();
        check("wr0.wreg", {27'd0, bus.exmem_wreg_o}, 32'd0);
        clr();
        bus.idex_aluop_i     = 3'b010;
        bus.idex_se_i        = 32'h22;
        bus.idex_regdst_i    = 1'b1;
        bus.idex_rd_i        = 5'd10;
        bus.idex_rsdata_i    = 32'h5;
        bus.memwb_regwrite_i = 1'b1;
        bus.memwb_data_i     = 32'h22;
        step();
        check("fwd.r0", bus.exmem_alu_o, 32'h5);

        clr();
        bus.idex_aluop_i  = 3'b001;
        bus.idex_branch_i = 1'b1;
        bus.idex_rs_i     = 5'd3;
        bus.idex_rt_i     = 5'd3;
        bus.idex_rsdata_i = 32'h77;
        bus.idex_rtdata_i = 32'h77;
        bus.idex_add_i    = 32'h100;
        bus.idex_se_i     = 32'd4;
        step();
        check("beq.zero", {31'd0, bus.exmem_zero_o}, 32'd1);
        check("beq.target", bus.exmem_target_o, 32'h110);
        check("beq.branch", {31'd0, bus.exmem_branch_o}, 32'd1);
        check("beq.wdata", bus.exmem_wdata_o, 32'h77);

        run_alu("or",      3'b100, 32'h0,    1'b0, 32'hF0,       32'h0F,       32'hFF);
        run_alu("and",     3'b101, 32'h0,    1'b0, 32'hFF,       32'h0F,       32'h0F);
        run_alu("lui",     3'b110, 32'h1234, 1'b1, 32'h0,        32'h0,        32'h1234_0000);
        run_alu("add111",  3'b111, 32'h0,    1'b0, 32'd3,        32'd4,        32'd7);
        run_alu("sub",     3'b001, 32'h0,    1'b0, 32'd3,        32'd5,        32'hFFFF_FFFE);
        run_alu("slt",     3'b011, 32'h0,    1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1);
        run_alu("slt.rt",  3'b010, 32'h2A,   1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1);
        run_alu("slt.rt0", 3'b010, 32'h2A,   1'b0, 32'd1,        32'hFFFF_FFFF, 32'd0);
        run_alu("and.rt",  3'b010, 32'h24,   1'b0, 32'hC,        32'hA,        32'h8);
        run_alu("or.rt",   3'b010, 32'h25,   1'b0, 32'hC,        32'hA,        32'hE);
        run_alu("sub.rt",  3'b010, 32'h22,   1'b0, 32'd1,        32'd1,        32'd0);
        run_alu("undef",   3'b010, 32'h3F,   1'b0, 32'd5,        32'd7,        32'd0);
        run_alu("addiwrap",3'b000, 32'd1,    1'b1, 32'hFFFF_FFFF, 32'd0,       32'd0);

        do_mult("mul1", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        do_mult("mul2", 32'd6, 32'd7, 32'd42);

        clr();
        bus.idex_aluop_i    = 3'b010;
        bus.idex_se_i       = 32'h18;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_rsdata_i   = 32'd9;
        bus.idex_rtdata_i   = 32'd9;
        repeat (11) step();
        check("midmul.stall", {31'd0, bus.stall_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.stall", {31'd0, bus.stall_o}, 32'd0);
        check("midrst.regwrite", {31'd0, bus.exmem_regwrite_o}, 32'd0);
        check("midrst.alu", bus.exmem_alu_o, 32'd0);
        clr();
        @(negedge clk) rst_n = 1'b1;
        #1;
        bus.idex_aluop_i    = 3'b000;
        bus.idex_alusrc_i   = 1'b1;
        bus.idex_regwrite_i = 1'b1;
        bus.idex_rsdata_i   = 32'd100;
        bus.idex_se_i       = 32'd23;
        step();
        check("postrst.alu", bus.exmem_alu_o, 32'd123);
        check("postrst.regwrite", {31'd0, bus.exmem_regwrite_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
